// File: rtl/counter_pkg.sv
// counter_pkg
// Shared types and helpers for the counter bank.
//   cnt_mode_e : wrap or saturate behaviour at the top of the count range
//   cnt_max    : all-ones value for a given bit width
//   slice_lo   : low bit index of channel ch within a packed per-channel bus
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Widest count the helpers below handle exactly.
    localparam int unsigned CNT_MAX_BITS = 31;

    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    function automatic int slice_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/counter_bank_ch.sv
// counter_bank_ch
// One counter channel: power-of-two prescaler, up-counter, terminal-count
// pulse, sticky overflow and a saturated flag (saturate mode only).
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   en        count enable
//   clr       synchronous clear (highest priority)
//   load      synchronous load of load_val
//   load_val  value taken on load
//   cnt       current count
//   tc        one-cycle pulse coincident with the wrap/saturate update
//   ovf       sticky overflow, cleared only by clr or reset
module counter_bank_ch
    import counter_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int PRESCALE_BITS = 1,
    parameter int SATURATE      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    // With no prescaler a single bit is kept, pinned at zero, so every
    // enabled edge sees the prescaler "at max".
    localparam int            PW      = (PRESCALE_BITS > 0) ? PRESCALE_BITS : 1;
    localparam logic [PW-1:0] PSC_MAX = PW'(cnt_max(PRESCALE_BITS));
    localparam cnt_mode_e     MODE    = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;

    logic [PW-1:0]  psc;
    logic [PW-1:0]  psc_nxt;
    logic           sat;
    logic           step;
    logic [WIDTH:0] inc;
    logic           at_max;

    assign psc_nxt = (psc == PSC_MAX) ? '0 : psc + PW'(1);
    assign step    = en && (psc == PSC_MAX);
    // Carry out of the widened increment marks cnt == all ones.
    assign inc     = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
    assign at_max  = inc[WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            psc <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            psc <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
            sat <= 1'b0;
        end else if (load) begin
            cnt <= load_val;
            psc <= '0;
            tc  <= 1'b0;
            sat <= 1'b0;
        end else if (en) begin
            psc <= psc_nxt;
            if (step) begin
                if (!at_max) begin
                    cnt <= inc[WIDTH-1:0];
                    tc  <= 1'b0;
                end else if (MODE == CNT_WRAP) begin
                    cnt <= '0;
                    tc  <= 1'b1;
                    ovf <= 1'b1;
                end else begin
                    // Hold at max; pulse only on the first saturating step.
                    ovf <= 1'b1;
                    tc  <= ~sat;
                    sat <= 1'b1;
                end
            end else begin
                tc <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: rtl/counter_bank.sv
// counter_bank
// Bank of NUM_CH independent prescaled up-counters.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   en        per-channel count enable
//   clr       per-channel synchronous clear
//   load      per-channel synchronous load
//   load_val  load values, channel i at [i*WIDTH +: WIDTH]
//   cnt       counts, channel i at [i*WIDTH +: WIDTH]
//   tc        per-channel one-cycle terminal-count pulse
//   ovf       per-channel sticky overflow flag
module counter_bank
    import counter_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int WIDTH         = 8,
    parameter int PRESCALE_BITS = 1,
    parameter int SATURATE      = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       clr,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    output logic [NUM_CH*WIDTH-1:0] cnt,
    output logic [NUM_CH-1:0]       tc,
    output logic [NUM_CH-1:0]       ovf
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int LO = slice_lo(i, WIDTH);

        counter_bank_ch #(
            .WIDTH         (WIDTH),
            .PRESCALE_BITS (PRESCALE_BITS),
            .SATURATE      (SATURATE)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (en[i]),
            .clr      (clr[i]),
            .load     (load[i]),
            .load_val (load_val[LO +: WIDTH]),
            .cnt      (cnt[LO +: WIDTH]),
            .tc       (tc[i]),
            .ovf      (ovf[i])
        );
    end

endmodule

// File: doc/counter_bank.md
Name: counter_bank

Overview:
Parametrised bank of independent up-counters. Each channel has a power-of-two prescaler, enable, synchronous clear, synchronous load, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. It is the generalised successor of the single prescaled test counter. It is used in unit-test sample designs to generate multi-channel, multi-width waveform data (FST/VCD) for the trace tools.

Parameters:
- NUM_CH, 2, number of independent channels (>=1)
- WIDTH, 8, count width per channel (>=2)
- PRESCALE_BITS, 1, prescaler width; count advances once every 2**PRESCALE_BITS enabled cycles (0 = every enabled cycle)
- SATURATE, 0, 0 = wrap max->0; 1 = hold at max

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- en  input  NUM_CH  per-channel count enable
- clr  input  NUM_CH  per-channel synchronous clear
- load  input  NUM_CH  per-channel synchronous load
- load_val  input  NUM_CH*WIDTH  load values; channel i at [i*WIDTH +: WIDTH]
- cnt  output  NUM_CH*WIDTH  counts; channel i at [i*WIDTH +: WIDTH]
- tc  output  NUM_CH  one-cycle terminal-count pulse
- ovf  output  NUM_CH  sticky overflow flag

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While reset=1, all of the following are 0 immediately (no clock needed): cnt, every prescaler, tc, ovf. First count activity is on the first rising clk edge after reset falls.
- Per-channel priority at each rising edge: clr > load > count. Channels are fully independent.
- clr=1: cnt<=0, prescaler<=0, ovf<=0, tc<=0.
- load=1 (clr=0): cnt<=load_val slice, prescaler<=0, tc<=0. ovf is unchanged.
- Count: only when en=1 and neither clr nor load is set.
  - Prescaler increments modulo 2**PRESCALE_BITS.
  - A count step occurs on the edge where the prescaler is at its max value. With PRESCALE_BITS=0, every enabled edge is a step.
- en=0: prescaler and cnt hold; tc<=0.
- Step with cnt<max: cnt<=cnt+1, tc<=0.
- Step with cnt==max (2**WIDTH-1), SATURATE=0: cnt<=0, tc<=1, ovf<=1.
- Step with cnt==max, SATURATE=1: cnt holds at max, ovf<=1. tc<=1 only if cnt was not already saturated (one pulse per saturation event, re-armed by clr or load).
- tc is registered and high for exactly one cycle, coincident with the cnt update it flags.
- Width rules: internal arithmetic is WIDTH+1 bits for the max compare; no truncation warnings.
- Reset asserted mid-prescale or mid-count: state is lost and everything returns to 0; there is no resume.

Decomposition:
- Shared package counter_pkg:
  - typedef cnt_mode_e {CNT_WRAP, CNT_SAT}
  - localparam helper for max value
  - slice-index function for the packed buses
- Sub-module counter_bank_ch: one channel (prescaler, counter, tc, ovf, saturated flag) with WIDTH, PRESCALE_BITS and SATURATE parameters. counter_bank instantiates NUM_CH copies in a generate loop and packs/unpacks the buses.

Test Plan:
- Basic count (defaults): reset=1 for 2 cycles, release, en=2'b01 for 20 rising edges -> cnt ch0 = 10, ch1 = 0, tc = 0, ovf = 0.
- Wrap: load ch0 = 0xFE, then en=1 for 4 edges -> cnt 0xFE, 0xFF, 0x00. tc pulses high for exactly one cycle with the 0xFF->0x00 update, ovf[0]=1 and remains 1 after 10 more edges.
- Saturate (SATURATE=1): load 0xFE, en=1 for 10 edges -> cnt stops at 0xFF, exactly one tc pulse, ovf=1. A subsequent clr gives cnt=0, ovf=0, and a later saturation gives a new tc pulse.
- Priority: clr=1 and load=1 with load_val=0x55 on the same edge -> cnt=0. Next edge load only -> 0x55. load during en on the prescaler-max edge -> 0x55, no increment.
- Async reset mid-run: count ch0 and ch1 to non-zero values with PRESCALE_BITS=0, assert reset between clock edges -> cnt, tc and ovf read 0 before the next rising edge.
- Channel independence (NUM_CH=4, WIDTH=4, PRESCALE_BITS=0): en=4'b1010 for 17 edges -> ch1 = ch3 = 1 with one tc pulse each on the 16th edge; ch0 = ch2 = 0.
